hgc_vga_sequencer: RTL and testbench

HGC_VGA_SEQUENCER -- requirements
Module: hgc_vga_sequencer

---
 rtl/hgc_pkg.sv | 32 +++
 rtl/hgc_timing_gen.sv | 65 ++++++
 rtl/hgc_vga_sequencer.sv | 112 +++++++++++
 tb/tb_hgc_vga_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hgc_pkg.sv
// Shared HGC display timing defaults and state encodings, reused by the sequencer and the CRTC.
package hgc_pkg;

  localparam int HGC_H_ACTIVE = 720;
  localparam int HGC_H_FP     = 18;
  localparam int HGC_H_SYNC   = 108;
  localparam int HGC_H_BP     = 54;
  localparam int HGC_V_ACTIVE = 350;
  localparam int HGC_V_FP     = 37;
  localparam int HGC_V_SYNC   = 2;
  localparam int HGC_V_BP     = 60;
  localparam bit HGC_HSYNC_POL = 1'b0;
  localparam bit HGC_VSYNC_POL = 1'b1;

  // One encoding serves both axes: H_ACT/H_FP/H_SYNC/H_BP and V_ACT/V_FP/V_SYNC/V_BP.
  typedef enum logic [1:0] {
    SEG_ACT  = 2'd0,
    SEG_FP   = 2'd1,
    SEG_SYNC = 2'd2,
    SEG_BP   = 2'd3
  } seg_e;

  typedef enum logic {
    RUN_STOP = 1'b0,
    RUN_RUN  = 1'b1
  } run_e;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/hgc_timing_gen.sv
// One timing axis: wrapping position counter plus ACT -> FP -> SYNC -> BP segment FSM.
// Advances once per i_adv; i_clr parks it at position 0 in ACT.
module hgc_timing_gen
  import hgc_pkg::*;
#(
  parameter int ACT   = HGC_H_ACTIVE,
  parameter int FP    = HGC_H_FP,
  parameter int SYNC  = HGC_H_SYNC,
  parameter int BP    = HGC_H_BP,
  parameter int CNT_W = $clog2(ACT + FP + SYNC + BP)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_cnt,
  output seg_e             o_seg,
  output logic             o_wrap
);

  localparam int TOTAL = ACT + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACT);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACT + FP);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACT + FP + SYNC);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  seg_e             r_seg;
  seg_e             w_seg_nxt;

  assign o_cnt  = r_cnt;
  assign o_seg  = r_seg;
  assign o_wrap = i_adv && !i_clr && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_seg <= SEG_ACT;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_seg_nxt = r_seg;
    if (i_clr) begin
      w_cnt_nxt = '0;
      w_seg_nxt = SEG_ACT;
    end else if (i_adv) begin
      w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      // Each segment is left when the next position crosses into the following one.
      case (r_seg)
        SEG_ACT:  if (w_cnt_nxt == FP_START)   w_seg_nxt = SEG_FP;
        SEG_FP:   if (w_cnt_nxt == SYNC_START) w_seg_nxt = SEG_SYNC;
        SEG_SYNC: if (w_cnt_nxt == BP_START)   w_seg_nxt = SEG_BP;
        SEG_BP:   if (w_cnt_nxt == '0)         w_seg_nxt = SEG_ACT;
        default:  w_seg_nxt = SEG_ACT;
      endcase
    end
  end

endmodule

// File: rtl/hgc_vga_sequencer.sv
// HGC display sequencer: drives pixel requests, gates returned pixel bits and generates VGA syncs.
// Colour and syncs appear two clocks after the timing state; run/stop only changes at frame end.
module hgc_vga_sequencer
  import hgc_pkg::*;
#(
  parameter int H_ACTIVE  = HGC_H_ACTIVE,
  parameter int H_FP      = HGC_H_FP,
  parameter int H_SYNC    = HGC_H_SYNC,
  parameter int H_BP      = HGC_H_BP,
  parameter int V_ACTIVE  = HGC_V_ACTIVE,
  parameter int V_FP      = HGC_V_FP,
  parameter int V_SYNC    = HGC_V_SYNC,
  parameter int V_BP      = HGC_V_BP,
  parameter bit HSYNC_POL = HGC_HSYNC_POL,
  parameter bit VSYNC_POL = HGC_VSYNC_POL
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic video_in,
  input  logic intensity_in,
  output logic pixel_req,
  output logic video,
  output logic intensity,
  output logic hsync,
  output logic vsync,
  output logic line_start,
  output logic frame_start
);

  localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  run_e           r_run_st;
  run_e           w_run_nxt;
  logic           w_running;
  logic [H_W-1:0] w_h_cnt;
  logic [V_W-1:0] w_v_cnt;
  seg_e           w_h_seg;
  seg_e           w_v_seg;
  logic           w_h_wrap;
  logic           w_v_wrap;
  logic           r_req_d;
  logic           r_hs_d;
  logic           r_vs_d;
  logic           r_video;
  logic           r_intensity;
  logic           r_hsync;
  logic           r_vsync;

  assign w_running = (r_run_st == RUN_RUN);

  hgc_timing_gen #(
    .ACT(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(H_W)
  ) u_h_timing (
    .clk(clk), .reset_n(reset_n), .i_clr(!w_running), .i_adv(w_running),
    .o_cnt(w_h_cnt), .o_seg(w_h_seg), .o_wrap(w_h_wrap)
  );

  hgc_timing_gen #(
    .ACT(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(V_W)
  ) u_v_timing (
    .clk(clk), .reset_n(reset_n), .i_clr(!w_running), .i_adv(w_h_wrap),
    .o_cnt(w_v_cnt), .o_seg(w_v_seg), .o_wrap(w_v_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_run_st <= RUN_STOP;
    else          r_run_st <= w_run_nxt;
  end

  // enable is only sampled at the last clock of V_BP, so a low pulse mid-frame is forgotten.
  always_comb begin
    w_run_nxt = r_run_st;
    case (r_run_st)
      RUN_STOP: if (enable) w_run_nxt = RUN_RUN;
      RUN_RUN:  if (w_v_wrap && !enable) w_run_nxt = RUN_STOP;
      default:  w_run_nxt = RUN_STOP;
    endcase
  end

  assign pixel_req   = w_running && (w_h_seg == SEG_ACT) && (w_v_seg == SEG_ACT);
  assign line_start  = w_running && (w_h_cnt == '0);
  assign frame_start = line_start && (w_v_cnt == '0);

  // Returned pixel arrives the clock after the request and is registered once more.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_d     <= 1'b0;
      r_hs_d      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_video     <= 1'b0;
      r_intensity <= 1'b0;
      r_hsync     <= ~HSYNC_POL;
      r_vsync     <= ~VSYNC_POL;
    end else begin
      r_req_d     <= pixel_req;
      r_hs_d      <= w_running && (w_h_seg == SEG_SYNC);
      r_vs_d      <= w_running && (w_v_seg == SEG_SYNC);
      r_video     <= r_req_d & video_in;
      r_intensity <= r_req_d & intensity_in;
      r_hsync     <= sync_level(r_hs_d, HSYNC_POL);
      r_vsync     <= sync_level(r_vs_d, VSYNC_POL);
    end
  end

  assign video     = r_video;
  assign intensity = r_intensity;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;

endmodule

// File: tb/tb_hgc_vga_sequencer.sv
// Bench for hgc_vga_sequencer on a shrunken 15 x 8 raster, checked against a frame-position model.
`timescale 1ns/1ps
module tb_hgc_vga_sequencer;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam bit HPOL = 1'b0, VPOL = 1'b1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0, video_in = 1'b0, intensity_in = 1'b0;
  logic pixel_req, video, intensity, hsync, vsync, line_start, frame_start;

  int n_checks = 0, n_errors = 0;
  int c_req, c_vid, c_hlow, c_vhigh, c_ls, c_fs;

  // Model state: running flag and clock position inside the frame.
  bit m_run;
  int m_pos;
  bit p_req1, p_hs1, p_vs1;
  bit e_video, e_int, e_hs, e_vs;

  always #5 clk = ~clk;

  hgc_vga_sequencer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .video_in(video_in), .intensity_in(intensity_in),
    .pixel_req(pixel_req), .video(video), .intensity(intensity),
    .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rb();
    return ($urandom & 32'd1) != 0;
  endfunction

  function automatic bit m_req();
    return m_run && (m_pos % HT) < HA && (m_pos / HT) < VA;
  endfunction

  function automatic bit m_hs();
    return m_run && (m_pos % HT) >= HA + HFP && (m_pos % HT) < HA + HFP + HS;
  endfunction

  function automatic bit m_vs();
    return m_run && (m_pos / HT) >= VA + VFP && (m_pos / HT) < VA + VFP + VS;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0;
    p_req1 = 0; p_hs1 = 0; p_vs1 = 0;
    e_video = 0; e_int = 0; e_hs = 0; e_vs = 0;
  endtask

  task automatic model_edge();
    if (!reset_n) return;
    e_video = p_req1 && video_in;
    e_int   = p_req1 && intensity_in;
    e_hs    = p_hs1;
    e_vs    = p_vs1;
    p_req1  = m_req();
    p_hs1   = m_hs();
    p_vs1   = m_vs();
    if (!m_run) begin
      if (enable) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == FT - 1) begin
      m_pos = 0;
      if (!enable) m_run = 0;
    end else begin
      m_pos++;
    end
  endtask

  task automatic compare_all();
    check("pixel_req", pixel_req, m_req());
    check("line_start", line_start, m_run && (m_pos % HT) == 0);
    check("frame_start", frame_start, m_run && m_pos == 0);
    check("video", video, e_video);
    check("intensity", intensity, e_int);
    check("hsync", hsync, e_hs ? HPOL : !HPOL);
    check("vsync", vsync, e_vs ? VPOL : !VPOL);
    c_req += pixel_req; c_vid += video; c_hlow += !hsync;
    c_vhigh += vsync; c_ls += line_start; c_fs += frame_start;
  endtask

  task automatic clear_counts();
    c_req = 0; c_vid = 0; c_hlow = 0; c_vhigh = 0; c_ls = 0; c_fs = 0;
  endtask

  task automatic check_reset_outputs(input string ph);
    check({ph, "_pixel_req"}, pixel_req, 0);
    check({ph, "_video"}, video, 0);
    check({ph, "_intensity"}, intensity, 0);
    check({ph, "_line_start"}, line_start, 0);
    check({ph, "_frame_start"}, frame_start, 0);
    check({ph, "_hsync"}, hsync, !HPOL);
    check({ph, "_vsync"}, vsync, !VPOL);
  endtask

  task automatic cycle(input bit en, input bit vin, input bit iin);
    @(negedge clk);
    compare_all();
    enable = en; video_in = vin; intensity_in = iin;
    @(posedge clk);
    model_edge();
  endtask

  task automatic release_reset(input bit en);
    @(negedge clk);
    reset_n = 1'b1; enable = en;
    @(posedge clk);
    model_edge();
  endtask

  task automatic reset_at(input int pos);
    int guard = 0;
    while (!(m_run && m_pos == pos) && guard < 4 * FT) begin
      cycle(1'b1, rb(), rb());
      guard++;
    end
    check("reach_reset_point", int'(guard < 4 * FT), 1);
    @(negedge clk);
    compare_all();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("mid_hold");
    release_reset(1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit en;
    clear_counts();
    model_reset();
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("por");
    enable = 1'b1;
    repeat (2) @(posedge clk);
    release_reset(1'b1);

    // Constant white pixels: settle one frame, then count a full frame.
    for (int i = 0; i < FT; i++) cycle(1'b1, 1'b1, 1'b1);
    clear_counts();
    for (int i = 0; i < FT; i++) cycle(1'b1, 1'b1, 1'b1);
    check("frame_req_count", c_req, HA * VA);
    check("frame_video_count", c_vid, HA * VA);
    check("frame_hsync_low", c_hlow, HS * VT);
    check("frame_vsync_high", c_vhigh, VS * HT);
    check("frame_line_starts", c_ls, VT);
    check("frame_starts", c_fs, 1);

    // Enable dropped at line 1 and restored at line 3: no interruption.
    clear_counts();
    for (int i = 0; i < 2 * FT; i++) cycle(!(i >= HT && i < 3 * HT), rb(), rb());
    check("glitch_free_frames", c_fs, 2);
    check("glitch_free_reqs", c_req, 2 * HA * VA);

    // Enable dropped at line 1 and held low: frame completes, then stop.
    clear_counts();
    for (int i = 0; i < 2 * FT; i++) cycle(i < HT, rb(), rb());
    check("stop_after_frame_reqs", c_req, HA * VA);
    check("stop_after_frame_starts", c_fs, 1);
    check("stopped_hsync_low", c_hlow, HS * VT);

    reset_at(2 * HT + 5);

    en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(39, 0) == 0) en = !en;
      cycle(en, rb(), rb());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
